sram_sp_init: RTL and testbench
===============================

Name: sram_sp_init

Overview:
- Parametrised single-port synchronous SRAM; successor to the fixed 8x8 SRAM1 block.
- Adds configurable width and depth, per-byte write enables, and a registered read with a valid strobe.
- Adds a hardware init sweep that clears the array after every reset.
- Sits between a local controller and its scratch storage; the controller waits for busy to deassert before issuing requests.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 3, address width.
- DEPTH, 2**ADDR_W, number of words; must be <= 2**ADDR_W.
- INIT_VAL, 0, value written to every word during the init sweep (DATA_W bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  write request.
- rd  in  1  read request.
- addr  in  ADDR_W  word address for the current request.
- data_in  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; be[i] covers data_in[8i+7:8i].
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse; data_out is valid.
- busy  out  1  init sweep in progress; requests are ignored.
- req_err  out  1  one-cycle pulse; request dropped (busy, or addr >= DEPTH).

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values, with rst high at an edge:
  - data_out = 0, rd_valid = 0, req_err = 0.
  - busy = 1.
  - FSM goes to INIT; init pointer = 0.
- Array contents are not reset directly; they are cleared by the sweep.
- FSM states: INIT and IDLE.
- INIT:
  - Each cycle writes INIT_VAL to mem[ptr], then ptr++.
  - When ptr == DEPTH-1 is written, the next state is IDLE and busy falls.
  - Sweep length is exactly DEPTH cycles: busy is high for DEPTH cycles after the reset edge.
- IDLE:
  - Write: when wr=1 and addr < DEPTH, for each i with be[i]=1, mem[addr] byte i takes data_in byte i at that edge. Bytes with be[i]=0 are unchanged.
  - be = 0 with wr=1 is a legal no-op write and raises no error.
  - Read: when rd=1 and addr < DEPTH, data_out is updated at the next edge and rd_valid pulses that same cycle. Latency is 1 cycle.
  - data_out holds its last value when no read occurs. rd_valid is low otherwise.
- Simultaneous wr and rd at the same address: write-first. data_out returns the merged word (new enabled bytes, old disabled bytes).
- Simultaneous wr and rd at different addresses: both are performed.
- Out-of-range address (addr >= DEPTH): the write is suppressed, and the read produces no rd_valid. req_err pulses the next cycle.
- Request while busy: no array change, no rd_valid. req_err pulses the next cycle.
- req_err pulses once per offending cycle, even if wr and rd are both set.
- rst asserted mid-sweep or mid-read: the sweep restarts from ptr=0, and any pending rd_valid is cancelled.
- Reset takes priority over every request in the same cycle.
- wr/rd with rst=1 are ignored and raise no req_err.

Decomposition:
- Package sram_pkg holds:
  - the state enum {ST_INIT, ST_IDLE};
  - localparam BE_W = DATA_W/8;
  - a byte-merge function merge(old, new, be) used by both the write path and the write-first bypass.
- Sub-module sram_init_ctrl: the FSM, init pointer, and busy output. It drives an override mux on write address, data and enable.
- Array and read register stay in the top level.

Test Plan (DATA_W=16, ADDR_W=3, DEPTH=6, INIT_VAL=16'hA5A5):
- Release rst and hold requests low -> busy high for exactly 6 cycles. Then read addr 0..5 -> each data_out = 16'hA5A5, rd_valid one cycle after each rd.
- After init, wr addr=1 data_in=16'h3E3E be=2'b11; then rd addr=1 -> data_out=16'h3E3E one cycle later, rd_valid pulse width 1.
- wr addr=2 data_in=16'h1234 be=2'b01; rd addr=2 -> 16'hA534. Then wr be=2'b10 data_in=16'hBEEF; rd -> 16'hBE34.
- Same cycle wr+rd addr=3 data_in=16'h00FF be=2'b10 -> data_out=16'h00A5 next cycle (write-first merge).
- rd addr=7 (>= DEPTH) -> no rd_valid, req_err pulse. Wr addr=6 -> req_err pulse, and a read of every valid address is unchanged.
- Assert rst at sweep cycle 3, release, and wr during busy -> busy restarts and lasts 6 cycles. The write during busy gives req_err; the array is all 16'hA5A5 afterwards.

Source files
------------

// File: rtl/sram_sp_init_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the sram_sp_init slice.
//   - state_t   : init-controller FSM states
//   - BYTE_W    : bits per byte lane
//   - merge()   : byte-lane merge used by both the array write path and the
//                 write-first read bypass, so the two can never disagree.
// merge() works on the widest supported word (MAX_DATA_W); callers zero-extend
// into it and take back the low DATA_W bits.
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / BYTE_W;

  // Byte enable width for a given data width (DATA_W/8).
  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // Enabled lanes take the new word, disabled lanes keep the old word.
  function automatic logic [MAX_DATA_W-1:0] merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   lane_en
  );
    logic [MAX_DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < int'(MAX_BE_W); i++) begin
      if (lane_en[i]) begin
        result[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end else begin
        result[i*BYTE_W +: BYTE_W] = old_word[i*BYTE_W +: BYTE_W];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_sp_init_if.sv
// -----------------------------------------------------------------------------
// sram_sp_init_if
// Request/response bundle between a local controller (master) and the
// single-port SRAM (slave).
//   wr, rd, addr, data_in, be     : request from controller
//   data_out, rd_valid            : registered read response
//   busy                          : init sweep running, requests are dropped
//   req_err                       : one-cycle pulse for a dropped request
// -----------------------------------------------------------------------------
interface sram_sp_init_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
  logic              req_err;

  modport master (
    output wr, rd, addr, data_in, be,
    input  data_out, rd_valid, busy, req_err
  );

  modport slave (
    input  wr, rd, addr, data_in, be,
    output data_out, rd_valid, busy, req_err
  );
endinterface

// File: rtl/sram_sp_init_init_ctrl.sv
// -----------------------------------------------------------------------------
// sram_init_ctrl
// Init sweep controller: after every reset it walks the array writing INIT_VAL
// to each word, one word per cycle, then hands the write port to the request
// path.
//   clk, rst      : clock, synchronous active-high reset
//   req_we        : qualified write request from the top level
//   req_addr      : request write address
//   req_data      : request write word (already byte-merged)
//   busy          : registered, high while the sweep runs
//   mem_we/mem_waddr/mem_wdata : array write port after the override mux
// -----------------------------------------------------------------------------
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DEPTH    = 2**ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              busy_r;

  // Sweep FSM: INIT walks ptr 0..DEPTH-1, then parks in IDLE until next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
      ptr_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (ptr_r == LAST_ADDR) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            ptr_r   <= ptr_r + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_INIT;
          ptr_r   <= '0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Write-port override: the sweep owns the port in INIT; a reset cycle writes nothing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (rst) begin
      mem_we    = 1'b0;
    end else if (state_r == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_r;
      mem_wdata = INIT_VAL;
    end else begin
      mem_we    = req_we;
      mem_waddr = req_addr;
      mem_wdata = req_data;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/sram_sp_init.sv
// -----------------------------------------------------------------------------
// sram_sp_init
// Parametrised single-port synchronous SRAM with per-byte write enables, a
// registered read (1-cycle latency, rd_valid strobe), write-first behaviour on
// a combined wr+rd, and a hardware sweep that fills the array with INIT_VAL
// after every reset.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : sram_sp_init_if slave modport (wr, rd, addr, data_in, be,
//          data_out, rd_valid, busy, req_err)
// -----------------------------------------------------------------------------
module sram_sp_init
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DEPTH    = 2**ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  sram_sp_init_if.slave   bus
);

  localparam int unsigned BE_W = be_width(DATA_W);
  // One bit wider than addr so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy_s;
  logic              in_range_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              err_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] merged_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  logic [DATA_W-1:0] data_out_r;
  logic              rd_valid_r;
  logic              req_err_r;

  // Request qualification: a request is honoured only when idle, in range, and not in reset.
  always_comb begin
    in_range_s = ({1'b0, bus.addr} < DEPTH_V);
    wr_ok_s    = bus.wr & ~busy_s & in_range_s & ~rst;
    rd_ok_s    = bus.rd & ~busy_s & in_range_s & ~rst;
    // Single error pulse per offending cycle, whether wr, rd or both were set.
    err_s      = (bus.wr | bus.rd) & (busy_s | ~in_range_s);
  end

  // Byte merge of the addressed word; feeds both the array write and the read bypass.
  always_comb begin
    logic [MAX_DATA_W-1:0] old_x;
    logic [MAX_DATA_W-1:0] new_x;
    logic [MAX_BE_W-1:0]   be_x;
    logic [MAX_DATA_W-1:0] res_x;
    old_x             = '0;
    new_x             = '0;
    be_x              = '0;
    rd_word_s         = mem[bus.addr];
    old_x[DATA_W-1:0] = rd_word_s;
    new_x[DATA_W-1:0] = bus.data_in;
    be_x[BE_W-1:0]    = bus.be;
    res_x             = merge(old_x, new_x, be_x);
    merged_s          = res_x[DATA_W-1:0];
  end

  sram_init_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT_VAL)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .req_we    (wr_ok_s),
    .req_addr  (bus.addr),
    .req_data  (merged_s),
    .busy      (busy_s),
    .mem_we    (mem_we_s),
    .mem_waddr (mem_waddr_s),
    .mem_wdata (mem_wdata_s)
  );

  // Array write port; contents are never reset, the sweep clears them instead.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Registered read response and error strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= '0;
      rd_valid_r <= 1'b0;
      req_err_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_ok_s;
      req_err_r  <= err_s;
      if (rd_ok_s) begin
        // Write-first: a same-cycle write is visible in the returned word.
        data_out_r <= wr_ok_s ? merged_s : rd_word_s;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.req_err  = req_err_r;
  assign bus.busy     = busy_s;

endmodule

// File: tb/tb_sram_sp_init.sv
module tb_sram_sp_init;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_sp_init_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sram_sp_init #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DP),
    .INIT_VAL (16'hA5A5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          at;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      err_q[$];
  rd_exp_t e_rd;
  int      e_err;
  int      n_cmp = 0;
  int      n_bad = 0;

  // Scoreboard monitor: pops expectations whenever the DUT strobes an output.
  always @(negedge clk) begin
    while (rd_q.size() > 0 && rd_q[0].at < cyc) begin
      e_rd = rd_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL rd_missing: no rd_valid at cycle %0d, required data %h", e_rd.at, e_rd.data);
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      e_err = err_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL err_missing: no req_err at cycle %0d, required pulse", e_err);
    end
    if (bus.rd_valid === 1'b1) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: rd_valid with data %h at cycle %0d, required none", bus.data_out, cyc);
      end else begin
        e_rd = rd_q.pop_front();
        if (bus.data_out !== e_rd.data || e_rd.at != cyc) begin
          n_bad++;
          $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d", bus.data_out, cyc, e_rd.data, e_rd.at);
        end
      end
    end
    if (bus.req_err === 1'b1) begin
      n_cmp++;
      if (err_q.size() == 0) begin
        n_bad++;
        $display("FAIL err_unexpected: req_err at cycle %0d, required none", cyc);
      end else begin
        e_err = err_q.pop_front();
        if (e_err != cyc) begin
          n_bad++;
          $display("FAIL err_cycle: req_err at cycle %0d, required cycle %0d", cyc, e_err);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic r, input logic [2:0] a,
                       input logic [15:0] d, input logic [1:0] b,
                       input logic exp_rd, input logic [15:0] exp_data,
                       input logic exp_err);
    rd_exp_t item;
    @(negedge clk);
    bus.wr = w; bus.rd = r; bus.addr = a; bus.data_in = d; bus.be = b;
    if (exp_rd) begin
      item.data = exp_data;
      item.at   = cyc + 1;
      rd_q.push_back(item);
    end
    if (exp_err) err_q.push_back(cyc + 1);
    @(posedge clk); #1;
    bus.wr = 1'b0; bus.rd = 1'b0;
  endtask

  // Reset edge, optional write during busy, then measure the busy length.
  task automatic reset_and_count(input logic wr_during);
    int n;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.req_err !== 1'b0 || bus.data_out !== 16'h0000 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_values: got rd_valid=%b req_err=%b data_out=%h busy=%b, required 0 0 0000 1",
               bus.rd_valid, bus.req_err, bus.data_out, bus.busy);
    end
    if (wr_during) begin
      bus.wr = 1'b1; bus.addr = 3'd0; bus.data_in = 16'h1111; bus.be = 2'b11;
      err_q.push_back(cyc + 1);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      bus.wr = 1'b0;
      n++;
    end
    n_cmp++;
    if (n != DP) begin
      n_bad++;
      $display("FAIL busy_len: got %0d cycles, required %0d", n, DP);
    end
  endtask

  logic [15:0] exp_tbl [DP];

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = 3'd0; bus.data_in = 16'h0000; bus.be = 2'b00;

    // Sweep after power-on reset, then every word holds INIT_VAL.
    reset_and_count(1'b0);
    for (int a = 0; a < DP; a++) issue(1'b0, 1'b1, 3'(a), 16'h0000, 2'b00, 1'b1, 16'hA5A5, 1'b0);

    // Full-word write then read.
    issue(1'b1, 1'b0, 3'd1, 16'h3E3E, 2'b11, 1'b0, 16'h0000, 1'b0);
    issue(1'b0, 1'b1, 3'd1, 16'h0000, 2'b00, 1'b1, 16'h3E3E, 1'b0);

    // Partial byte writes.
    issue(1'b1, 1'b0, 3'd2, 16'h1234, 2'b01, 1'b0, 16'h0000, 1'b0);
    issue(1'b0, 1'b1, 3'd2, 16'h0000, 2'b00, 1'b1, 16'hA534, 1'b0);
    issue(1'b1, 1'b0, 3'd2, 16'hBEEF, 2'b10, 1'b0, 16'h0000, 1'b0);
    issue(1'b0, 1'b1, 3'd2, 16'h0000, 2'b00, 1'b1, 16'hBE34, 1'b0);

    // Same-cycle write+read: write-first merge.
    issue(1'b1, 1'b1, 3'd3, 16'h00FF, 2'b10, 1'b1, 16'h00A5, 1'b0);

    // be = 0 write is a silent no-op.
    issue(1'b1, 1'b0, 3'd4, 16'hFFFF, 2'b00, 1'b0, 16'h0000, 1'b0);
    issue(1'b0, 1'b1, 3'd4, 16'h0000, 2'b00, 1'b1, 16'hA5A5, 1'b0);

    // Out-of-range requests.
    issue(1'b0, 1'b1, 3'd7, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b1);
    issue(1'b1, 1'b0, 3'd6, 16'hFFFF, 2'b11, 1'b0, 16'h0000, 1'b1);
    issue(1'b1, 1'b1, 3'd7, 16'hFFFF, 2'b11, 1'b0, 16'h0000, 1'b1);

    exp_tbl[0] = 16'hA5A5; exp_tbl[1] = 16'h3E3E; exp_tbl[2] = 16'hBE34;
    exp_tbl[3] = 16'h00A5; exp_tbl[4] = 16'hA5A5; exp_tbl[5] = 16'hA5A5;
    for (int a = 0; a < DP; a++) issue(1'b0, 1'b1, 3'(a), 16'h0000, 2'b00, 1'b1, exp_tbl[a], 1'b0);

    // Reset mid-sweep: sweep restarts, write during busy is rejected.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    reset_and_count(1'b1);
    for (int a = 0; a < DP; a++) issue(1'b0, 1'b1, 3'(a), 16'h0000, 2'b00, 1'b1, 16'hA5A5, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rd_q.size() != 0 || err_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d reads and %0d errors outstanding, required 0 and 0", rd_q.size(), err_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
